// File: rtl/usb_pkg.sv
// Shared constants and types for the USB receive data path.
package usb_pkg;

  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  // Reflected x^16+x^15+x^2+1; register bit 0 holds the x^15 coefficient.
  localparam logic [15:0] CRC16_POLY = 16'hA001;
  // Good-packet remainder (x^15+x^3+x^2+1) in the same reflected bit order.
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK
  } rx_ctrl_state_t;

endpackage

// File: rtl/usb_rx_data_ctrl_if.sv
// Byte-decoder / FIFO / status bundle around the USB receive data controller.
interface usb_rx_data_ctrl_if #(
  parameter int LEN_W = 11
);
  logic             rx_start;
  logic [7:0]       rx_byte;
  logic             rx_byte_valid;
  logic             rx_eop;
  logic             rx_abort;
  logic             fifo_full;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             pkt_done;
  logic             pkt_ok;
  logic             err_crc;
  logic             err_short;
  logic             err_long;
  logic             err_ovf;
  logic             err_abort;
  logic [LEN_W-1:0] pkt_len;

  modport master (
    output rx_start, rx_byte, rx_byte_valid, rx_eop, rx_abort, fifo_full,
    input  out_data, out_valid, pkt_done, pkt_ok,
           err_crc, err_short, err_long, err_ovf, err_abort, pkt_len
  );

  modport slave (
    input  rx_start, rx_byte, rx_byte_valid, rx_eop, rx_abort, fifo_full,
    output out_data, out_valid, pkt_done, pkt_ok,
           err_crc, err_short, err_long, err_ovf, err_abort, pkt_len
  );

endinterface

// File: rtl/usb_crc16_sclr.sv
// Byte-wide USB CRC16 engine (LSB-first data) with synchronous clear.
module usb_crc16_sclr
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        crc_clr,
  input  logic        crc_en,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out,
  output logic        flag
);

  logic [15:0] crc_q;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[15:1]};
      if (fb) r = r ^ CRC16_POLY;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)       crc_q <= CRC16_INIT;
    else if (crc_clr) crc_q <= CRC16_INIT;
    else if (crc_en)  crc_q <= crc16_byte(crc_q, data_in);
  end

  assign crc_out = crc_q;
  assign flag    = (crc_q == CRC16_RESIDUAL);

endmodule

// File: rtl/usb_rx_data_ctrl.sv
// Receive data controller: CRC16 checking, 2-byte CRC hold-back, payload push, status.
module usb_rx_data_ctrl
  import usb_pkg::*;
#(
  parameter int MAX_PAYLOAD = 1023,
  parameter int LEN_W       = 11
) (
  input  logic               clk,
  input  logic               n_rst,
  usb_rx_data_ctrl_if.slave  bus
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);

  rx_ctrl_state_t   state, state_nxt;
  logic [7:0]       buf0, buf1;
  logic [1:0]       buf_cnt;
  logic [LEN_W-1:0] pay_cnt, len_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             abort_q;
  logic             err_crc_q, err_short_q, err_long_q, err_ovf_q, err_abort_q, ok_q;
  logic             crc_clr, crc_en, done, abort_go;
  logic             crc_flag;
  logic [15:0]      crc_unused;
  logic             abort_eff, chk_short, chk_crc, chk_ok;

  usb_crc16_sclr u_crc (
    .clk     (clk),
    .n_rst   (n_rst),
    .crc_clr (crc_clr),
    .crc_en  (crc_en),
    .data_in (bus.rx_byte),
    .crc_out (crc_unused),
    .flag    (crc_flag)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // An abort in RECV is reported through the single CHECK cycle like an EOP.
  always_comb begin
    state_nxt = state;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    done      = 1'b0;
    abort_go  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_start) begin
          crc_clr   = 1'b1;
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (bus.rx_start) begin
          crc_clr = 1'b1;
        end else if (bus.rx_abort) begin
          abort_go  = 1'b1;
          state_nxt = CHECK;
        end else begin
          crc_en = bus.rx_byte_valid;
          if (bus.rx_eop) state_nxt = CHECK;
        end
      end
      CHECK: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign abort_eff = abort_q | bus.rx_abort;
  assign chk_short = !abort_eff && (buf_cnt != 2'd2);
  assign chk_crc   = !abort_eff && !chk_short && !crc_flag;
  assign chk_ok    = !(abort_eff || chk_short || chk_crc || err_ovf_q || err_long_q);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      buf_cnt     <= 2'd0;
      pay_cnt     <= '0;
      len_q       <= '0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      abort_q     <= 1'b0;
      err_crc_q   <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_abort_q <= 1'b0;
      ok_q        <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (crc_clr) begin
        buf_cnt     <= 2'd0;
        pay_cnt     <= '0;
        len_q       <= '0;
        abort_q     <= 1'b0;
        err_crc_q   <= 1'b0;
        err_short_q <= 1'b0;
        err_long_q  <= 1'b0;
        err_ovf_q   <= 1'b0;
        err_abort_q <= 1'b0;
        ok_q        <= 1'b0;
      end else if (abort_go) begin
        abort_q <= 1'b1;
        buf_cnt <= 2'd0;
      end else if (crc_en) begin
        if (buf_cnt != 2'd2) begin
          buf_cnt <= buf_cnt + 2'd1;
        end else if (pay_cnt == MAX_LEN) begin
          err_long_q <= 1'b1;
        end else begin
          pay_cnt <= pay_cnt + LEN_W'(1);
          if (bus.fifo_full) begin
            err_ovf_q <= 1'b1;
          end else begin
            valid_q <= 1'b1;
            data_q  <= buf0;
            len_q   <= len_q + LEN_W'(1);
          end
        end
      end
      if (done) begin
        err_crc_q   <= chk_crc;
        err_short_q <= chk_short;
        err_abort_q <= abort_eff;
        ok_q        <= chk_ok;
        abort_q     <= 1'b0;
      end
    end
  end

  // Hold-back buffer: buf0 is the oldest byte; occupancy lives in buf_cnt.
  always_ff @(posedge clk) begin
    if (crc_en) begin
      case (buf_cnt)
        2'd0:    buf0 <= bus.rx_byte;
        2'd1:    buf1 <= bus.rx_byte;
        default: begin
          buf0 <= buf1;
          buf1 <= bus.rx_byte;
        end
      endcase
    end
  end

  // Status is live during the CHECK cycle so it is valid alongside pkt_done.
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.pkt_done  = done;
  assign bus.pkt_ok    = ok_q        | (done & chk_ok);
  assign bus.err_crc   = err_crc_q   | (done & chk_crc);
  assign bus.err_short = err_short_q | (done & chk_short);
  assign bus.err_abort = err_abort_q | (done & abort_eff);
  assign bus.err_long  = err_long_q;
  assign bus.err_ovf   = err_ovf_q;
  assign bus.pkt_len   = len_q;

endmodule

// File: tb/tb_usb_rx_data_ctrl.sv
// Directed bench for usb_rx_data_ctrl with an independent MSB-first USB CRC16 model.
module tb_usb_rx_data_ctrl;

  typedef logic [7:0] byte_q_t [$];

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   checks;
  int   errors;
  logic [7:0] outq [$];

  always #5 clk = ~clk;

  usb_rx_data_ctrl_if #(.LEN_W(11)) bus ();

  usb_rx_data_ctrl #(.MAX_PAYLOAD(1023), .LEN_W(11)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always @(negedge clk) if (bus.out_valid) outq.push_back(bus.out_data);

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wire-order CRC: x^15 coefficient transmitted first, bytes LSB first.
  function automatic byte_q_t with_crc(input byte_q_t p);
    byte_q_t     r;
    logic [15:0] c;
    logic [7:0]  b0, b1;
    logic        fb;
    r = p;
    c = 16'hFFFF;
    foreach (p[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ p[k][i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    for (int i = 0; i < 8; i++) begin
      b0[i] = ~c[15-i];
      b1[i] = ~c[7-i];
    end
    r.push_back(b0);
    r.push_back(b1);
    return r;
  endfunction

  // Returns at the falling edge inside the cycle that should carry pkt_done.
  task automatic send_pkt(input byte_q_t bytes, input int full_at);
    outq.delete();
    bus.rx_start = 1'b1;
    cyc();
    bus.rx_start = 1'b0;
    foreach (bytes[i]) begin
      bus.rx_byte       = bytes[i];
      bus.rx_byte_valid = 1'b1;
      bus.fifo_full     = (i == full_at);
      bus.rx_eop        = (i == bytes.size() - 1);
      if (i == bytes.size() - 1) begin
        @(negedge clk);
        check("done_early", bus.pkt_done, 1'b0);
      end
      cyc();
    end
    bus.rx_byte_valid = 1'b0;
    bus.rx_eop        = 1'b0;
    bus.fifo_full     = 1'b0;
    @(negedge clk);
  endtask

  byte_q_t pay, pkt;

  initial begin
    checks = 0;
    errors = 0;
    bus.rx_start      = 1'b0;
    bus.rx_byte       = 8'h00;
    bus.rx_byte_valid = 1'b0;
    bus.rx_eop        = 1'b0;
    bus.rx_abort      = 1'b0;
    bus.fifo_full     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data",  bus.out_data,  8'h00);
    check("rst_pkt_done",  bus.pkt_done,  1'b0);
    check("rst_pkt_ok",    bus.pkt_ok,    1'b0);
    check("rst_errs", {bus.err_crc, bus.err_short, bus.err_long, bus.err_ovf, bus.err_abort}, 5'b0);
    check("rst_pkt_len",   bus.pkt_len,   11'd0);
    n_rst = 1'b1;
    cyc();

    // empty payload: CRC bytes alone
    pkt = '{8'h00, 8'h00};
    send_pkt(pkt, -1);
    check("t1_done", bus.pkt_done, 1'b1);
    check("t1_ok",   bus.pkt_ok,   1'b1);
    check("t1_len",  bus.pkt_len,  11'd0);
    cyc(); cyc();
    check("t1_pushes", outq.size(), 0);
    check("t1_done_pulse", bus.pkt_done, 1'b0);

    pay = '{8'h00, 8'h01, 8'h02, 8'h03};
    pkt = with_crc(pay);
    send_pkt(pkt, -1);
    check("t2_done", bus.pkt_done, 1'b1);
    check("t2_ok",   bus.pkt_ok,   1'b1);
    check("t2_crc",  bus.err_crc,  1'b0);
    check("t2_len",  bus.pkt_len,  11'd4);
    cyc(); cyc();
    check("t2_pushes", outq.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_byte%0d", i), outq[i], pay[i]);
    check("t2_ok_held", bus.pkt_ok, 1'b1);

    pkt[2] = pkt[2] ^ 8'h01;
    send_pkt(pkt, -1);
    check("t2b_done",  bus.pkt_done,  1'b1);
    check("t2b_crc",   bus.err_crc,   1'b1);
    check("t2b_ok",    bus.pkt_ok,    1'b0);
    check("t2b_short", bus.err_short, 1'b0);
    cyc(); cyc();
    check("t2b_crc_held", bus.err_crc, 1'b1);

    pkt = '{8'hA5};
    send_pkt(pkt, -1);
    check("t3_done",  bus.pkt_done,  1'b1);
    check("t3_short", bus.err_short, 1'b1);
    check("t3_crc",   bus.err_crc,   1'b0);
    check("t3_ok",    bus.pkt_ok,    1'b0);
    check("t3_len",   bus.pkt_len,   11'd0);
    cyc(); cyc();
    check("t3_pushes", outq.size(), 0);

    // third push (payload byte 2) coincides with accepting byte index 4
    pkt = with_crc(pay);
    send_pkt(pkt, 4);
    check("t4_ovf", bus.err_ovf, 1'b1);
    check("t4_len", bus.pkt_len, 11'd3);
    check("t4_ok",  bus.pkt_ok,  1'b0);
    check("t4_crc", bus.err_crc, 1'b0);
    cyc(); cyc();
    check("t4_pushes", outq.size(), 3);
    check("t4_byte2",  outq[2], 8'h03);

    outq.delete();
    bus.rx_start = 1'b1;
    cyc();
    bus.rx_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rx_byte       = 8'h20 + 8'(i);
      bus.rx_byte_valid = 1'b1;
      cyc();
    end
    bus.rx_byte_valid = 1'b0;
    bus.rx_abort = 1'b1;
    cyc();
    bus.rx_abort = 1'b0;
    @(negedge clk);
    check("t5_done",  bus.pkt_done,  1'b1);
    check("t5_abort", bus.err_abort, 1'b1);
    check("t5_ok",    bus.pkt_ok,    1'b0);
    check("t5_crc",   bus.err_crc,   1'b0);
    cyc();
    bus.rx_eop = 1'b1;
    cyc();
    bus.rx_eop = 1'b0;
    @(negedge clk);
    check("t5_idle_eop", bus.pkt_done, 1'b0);
    check("t5_abort_held", bus.err_abort, 1'b1);

    cyc();
    bus.rx_start = 1'b1;
    cyc();
    bus.rx_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rx_byte       = 8'h30 + 8'(i);
      bus.rx_byte_valid = 1'b1;
      cyc();
    end
    bus.rx_byte_valid = 1'b0;
    @(negedge clk);
    check("t5_pre_valid", bus.out_valid, 1'b1);
    check("t5_pre_data",  bus.out_data,  8'h30);
    check("t5_pre_len",   bus.pkt_len,   11'd1);
    n_rst = 1'b0;
    #1;
    check("t5_rst_valid", bus.out_valid, 1'b0);
    check("t5_rst_data",  bus.out_data,  8'h00);
    check("t5_rst_len",   bus.pkt_len,   11'd0);
    check("t5_rst_done",  bus.pkt_done,  1'b0);
    #1;
    n_rst = 1'b1;
    cyc();
    pkt = with_crc(pay);
    send_pkt(pkt, -1);
    check("t5_after_ok",  bus.pkt_ok,  1'b1);
    check("t5_after_len", bus.pkt_len, 11'd4);
    cyc(); cyc();

    pay.delete();
    for (int i = 0; i < 1024; i++) pay.push_back(8'(i));
    pkt = with_crc(pay);
    send_pkt(pkt, -1);
    check("t6_done", bus.pkt_done, 1'b1);
    check("t6_long", bus.err_long, 1'b1);
    check("t6_len",  bus.pkt_len,  11'd1023);
    check("t6_crc",  bus.err_crc,  1'b0);
    check("t6_ok",   bus.pkt_ok,   1'b0);
    cyc(); cyc();
    check("t6_pushes", outq.size(), 1023);
    check("t6_last",   outq[1022], 8'hFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
